// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one combinational rv32i ALU. Each transaction is
// registered through IDLE -> EXEC -> RESP and answered on the winning port.

module alu #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OPW-1:0]   ALUOp,
   output logic [WIDTH-1:0] ALURes
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0] shamt;

   assign shamt = B[SHW-1:0];

   // Unknown op codes fall through to zero.
   always_comb begin
      ALURes = '0;
      case (ALUOp)
         4'b0000: ALURes = A + B;
         4'b1000: ALURes = A - B;
         4'b0001: ALURes = A << shamt;
         4'b0010: ALURes = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         4'b0011: ALURes = {{(WIDTH-1){1'b0}}, (A < B)};
         4'b0100: ALURes = A ^ B;
         4'b0101: ALURes = A >> shamt;
         4'b1101: ALURes = $signed(A) >>> shamt;
         4'b0110: ALURes = A | B;
         4'b0111: ALURes = A & B;
         4'b1001: ALURes = B;
         default: ALURes = '0;
      endcase
   end

endmodule

module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4,
   parameter int RR    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [OPW-1:0]   req_op0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [OPW-1:0]   req_op1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_res,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [OPW-1:0]   op_q;
   logic             gnt_q;
   logic             lastGrant_q;
   logic [WIDTH-1:0] res_q;
   logic [1:0]       rspValid_q;
   logic             grant_d;
   logic             accept;
   logic [WIDTH-1:0] aluRes;

   // On a tie the round-robin mode favours the port that did not win last.
   always_comb begin
      grant_d = 1'b0;
      case (req_valid)
         2'b01:   grant_d = 1'b0;
         2'b10:   grant_d = 1'b1;
         2'b11:   grant_d = (RR != 0) ? ~lastGrant_q : 1'b0;
         default: grant_d = 1'b0;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      if (state_q == IDLE && req_valid != 2'b00) begin
         req_ready = grant_d ? 2'b10 : 2'b01;
      end
   end

   assign accept = (req_valid & req_ready) != 2'b00;

   alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
      .A      (a_q),
      .B      (b_q),
      .ALUOp  (op_q),
      .ALURes (aluRes)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         gnt_q       <= 1'b0;
         lastGrant_q <= 1'b1;
         res_q       <= '0;
         rspValid_q  <= 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q         <= grant_d ? req_a1 : req_a0;
                  b_q         <= grant_d ? req_b1 : req_b0;
                  op_q        <= grant_d ? req_op1 : req_op0;
                  gnt_q       <= grant_d;
                  lastGrant_q <= grant_d;
                  state_q     <= EXEC;
               end
            end
            EXEC: begin
               res_q      <= aluRes;
               rspValid_q <= gnt_q ? 2'b10 : 2'b01;
               state_q    <= RESP;
            end
            RESP: begin
               // Only the granted port's ready may retire the response.
               if (rsp_ready[gnt_q]) begin
                  rspValid_q <= 2'b00;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rspValid_q;
   assign rsp_res   = res_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected results are queued at accept
// and compared when the arbiter returns a response.

module tb_alu_arbiter;

   typedef struct {
      int          port;
      logic [31:0] res;
   } sbEntry_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  rsp_ready = 2'b11;
   logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
   logic [3:0]  req_op0 = '0, req_op1 = '0;
   logic [1:0]  req_ready, rsp_valid;
   logic [31:0] rsp_res;
   logic        busy;

   logic [1:0]  fpValid = 2'b00;
   logic [1:0]  fpReqReady, fpRspValid;
   logic [31:0] fpRes;
   logic        fpBusy;

   sbEntry_t sb[$];
   int checkCount = 0;
   int passCount = 0;

   logic [31:0] opA [8] = '{32'h0F00F00F, 32'h80000000, 32'h00000001, 32'h7FFFFFFF,
                            32'h00000000, 32'h00000005, 32'hAAAAAAAA, 32'h80000000};
   logic [31:0] opB [8] = '{32'h10010010, 32'h00000004, 32'h00000021, 32'h00000001,
                            32'h00000001, 32'h00000006, 32'hFFFFFFFF, 32'h0000001F};
   logic [3:0]  opC [8] = '{4'b0110, 4'b0101, 4'b0001, 4'b0000,
                            4'b1000, 4'b1111, 4'b0100, 4'b1101};
   logic [31:0] opR [8] = '{32'h1F01F01F, 32'h08000000, 32'h00000002, 32'h80000000,
                            32'hFFFFFFFF, 32'h00000000, 32'h55555555, 32'hFFFFFFFF};

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(32), .OPW(4), .RR(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
      .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .busy(busy)
   );

   alu_arbiter #(.WIDTH(32), .OPW(4), .RR(0)) dutFixed (
      .clk(clk), .rst_n(rst_n), .req_valid(fpValid), .req_ready(fpReqReady),
      .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
      .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
      .rsp_valid(fpRspValid), .rsp_ready(2'b11), .rsp_res(fpRes), .busy(fpBusy)
   );

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 2'b00;
      fpValid = 2'b00;
      rsp_ready = 2'b11;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drives one request and waits (bounded) for its accept; returns at the negedge after it.
   task automatic applyStimulus(input int port, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] op, input logic [31:0] expRes);
      bit ok;
      ok = 1'b0;
      if (port == 0) begin
         req_a0 = a; req_b0 = b; req_op0 = op;
      end else begin
         req_a1 = a; req_b1 = b; req_op1 = op;
      end
      req_valid[port] = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         #1;
         if (req_ready[port]) begin
            @(posedge clk);
            sb.push_back('{port, expRes});
            ok = 1'b1;
         end
         @(negedge clk);
      end
      req_valid[port] = 1'b0;
      checkCount++;
      if (ok) passCount++;
      else $display("[TB] FAIL accept_port%0d: accepted=0 required=1", port);
   endtask

   // Waits (bounded) for a response starting at a negedge and consumes it.
   task automatic waitResp(output int port, output logic [31:0] res, output bit timedOut);
      timedOut = 1'b1;
      port = 0;
      res = '0;
      for (int i = 0; i < 60; i++) begin
         if (rsp_valid != 2'b00) begin
            port = rsp_valid[1] ? 1 : 0;
            res = rsp_res;
            timedOut = 1'b0;
            break;
         end
         @(negedge clk);
      end
      if (!timedOut) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checkCount++;
      if (rsp_valid === 2'b00 && busy === 1'b0 && rsp_res === 32'h0 && req_ready === 2'b00)
         passCount++;
      else
         $display("[TB] FAIL reset_state: rsp_valid=%b busy=%b rsp_res=%h req_ready=%b required 00/0/0/00",
                  rsp_valid, busy, rsp_res, req_ready);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      sbEntry_t e;
      doReset();
      req_a0 = 32'd10; req_b0 = 32'd5; req_op0 = 4'b0000;
      req_valid = 2'b01;
      #1;
      checkCount++;
      if (req_ready === 2'b01) passCount++;
      else $display("[TB] FAIL single_ready: req_ready=%b required 01", req_ready);
      @(posedge clk);
      sb.push_back('{0, 32'd15});
      @(negedge clk);
      req_valid = 2'b00;
      checkCount++;
      if (rsp_valid === 2'b00 && busy === 1'b1) passCount++;
      else $display("[TB] FAIL single_exec: rsp_valid=%b busy=%b required 00/1", rsp_valid, busy);
      @(negedge clk);
      e = sb.pop_front();
      checkCount++;
      if (rsp_valid === (e.port == 1 ? 2'b10 : 2'b01) && rsp_res === e.res) passCount++;
      else $display("[TB] FAIL single_resp: rsp_valid=%b rsp_res=%h required port%0d res=%h",
                    rsp_valid, rsp_res, e.port, e.res);
      @(negedge clk);
      checkCount++;
      if (rsp_valid === 2'b00 && busy === 1'b0) passCount++;
      else $display("[TB] FAIL single_done: rsp_valid=%b busy=%b required 00/0", rsp_valid, busy);
   endtask

   task automatic test_contention();
      doReset();
      fork
         applyStimulus(0, 32'd10, 32'd20, 4'b1000, 32'hFFFFFFF6);
         applyStimulus(1, 32'd3, 32'd2, 4'b0001, 32'd12);
         begin
            for (int k = 0; k < 2; k++) begin
               int p;
               logic [31:0] r;
               bit to;
               sbEntry_t e;
               waitResp(p, r, to);
               checkCount++;
               if (!to && sb.size() > 0) begin
                  e = sb.pop_front();
                  if (p === e.port && r === e.res && p === k) passCount++;
                  else $display("[TB] FAIL contention_resp%0d: port=%0d res=%h required port%0d res=%h",
                                k, p, r, k, e.res);
               end else begin
                  $display("[TB] FAIL contention_resp%0d: no response, required one", k);
               end
            end
         end
      join
   endtask

   task automatic test_round_robin();
      int grants, resps;
      logic [1:0] expReady;
      sbEntry_t e;
      doReset();
      grants = 0;
      resps = 0;
      req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = 4'b0000;
      req_a1 = 32'd2; req_b1 = 32'd2; req_op1 = 4'b0000;
      req_valid = 2'b11;
      for (int i = 0; i < 60 && resps < 4; i++) begin
         #1;
         if (req_ready != 2'b00 && grants < 4) begin
            expReady = (grants % 2 == 0) ? 2'b01 : 2'b10;
            checkCount++;
            if (req_ready === expReady) passCount++;
            else $display("[TB] FAIL rr_grant%0d: req_ready=%b required %b", grants, req_ready, expReady);
            sb.push_back('{grants % 2, (grants % 2 == 0) ? 32'd2 : 32'd4});
            grants++;
         end
         if (rsp_valid != 2'b00) begin
            checkCount++;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               if (rsp_valid === (e.port == 1 ? 2'b10 : 2'b01) && rsp_res === e.res) passCount++;
               else $display("[TB] FAIL rr_resp%0d: rsp_valid=%b res=%h required port%0d res=%h",
                             resps, rsp_valid, rsp_res, e.port, e.res);
            end else begin
               $display("[TB] FAIL rr_resp%0d: unexpected response rsp_valid=%b", resps, rsp_valid);
            end
            resps++;
         end
         @(negedge clk);
         if (grants == 4) req_valid = 2'b00;
      end
      req_valid = 2'b00;
      checkCount++;
      if (resps == 4) passCount++;
      else $display("[TB] FAIL rr_count: responses=%0d required 4", resps);
   endtask

   task automatic test_fixed_priority();
      int n;
      doReset();
      n = 0;
      req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = 4'b0000;
      req_a1 = 32'd2; req_b1 = 32'd2; req_op1 = 4'b0000;
      fpValid = 2'b11;
      for (int i = 0; i < 60 && n < 4; i++) begin
         if (fpRspValid != 2'b00) begin
            checkCount++;
            if (fpRspValid === 2'b01 && fpRes === 32'd2) passCount++;
            else $display("[TB] FAIL fp_resp%0d: rsp_valid=%b res=%h required 01 res=00000002",
                          n, fpRspValid, fpRes);
            n++;
         end
         @(negedge clk);
      end
      fpValid = 2'b00;
      checkCount++;
      if (n == 4) passCount++;
      else $display("[TB] FAIL fp_count: responses=%0d required 4", n);
   endtask

   task automatic test_backpressure();
      int p;
      logic [31:0] r;
      bit to;
      sbEntry_t e;
      doReset();
      rsp_ready = 2'b00;
      applyStimulus(1, 32'hFFFFFFFB, 32'd3, 4'b0011, 32'd0);
      req_a0 = 32'd7; req_b0 = 32'd8; req_op0 = 4'b0000;
      req_valid[0] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         checkCount++;
         if (rsp_valid === 2'b10 && rsp_res === 32'd0 && req_ready === 2'b00 && busy === 1'b1)
            passCount++;
         else
            $display("[TB] FAIL hold_cycle%0d: rsp_valid=%b res=%h req_ready=%b busy=%b required 10/0/00/1",
                     i, rsp_valid, rsp_res, req_ready, busy);
         @(negedge clk);
      end
      req_valid[0] = 1'b0;
      rsp_ready = 2'b11;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) applyStimulus(1, 32'hFFFFFFFB, 32'd3, 4'b0010, 32'd1);
         if (k == 2) applyStimulus(0, 32'hFFFFFFC0, 32'd3, 4'b1101, 32'hFFFFFFF8);
         waitResp(p, r, to);
         checkCount++;
         if (!to && sb.size() > 0) begin
            e = sb.pop_front();
            if (p === e.port && r === e.res) passCount++;
            else $display("[TB] FAIL bp_resp%0d: port=%0d res=%h required port%0d res=%h",
                          k, p, r, e.port, e.res);
         end else begin
            $display("[TB] FAIL bp_resp%0d: no response, required one", k);
         end
      end
   endtask

   task automatic test_reset_mid_exec();
      bit quiet;
      rsp_ready = 2'b11;
      req_a0 = 32'hF0F0F0F0; req_b0 = 32'h0F0F0F0F; req_op0 = 4'b0100;
      req_valid = 2'b01;
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      checkCount++;
      if (busy === 1'b1) passCount++;
      else $display("[TB] FAIL rst_exec_busy: busy=%b required 1", busy);
      rst_n = 1'b0;
      @(negedge clk);
      checkCount++;
      if (rsp_valid === 2'b00 && busy === 1'b0 && rsp_res === 32'h0) passCount++;
      else $display("[TB] FAIL rst_exec_idle: rsp_valid=%b busy=%b res=%h required 00/0/0",
                    rsp_valid, busy, rsp_res);
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid !== 2'b00) quiet = 1'b0;
      end
      checkCount++;
      if (quiet) passCount++;
      else $display("[TB] FAIL rst_exec_drop: a response appeared, required none");
   endtask

   task automatic test_wrong_port();
      int p;
      logic [31:0] r;
      bit to, held;
      sbEntry_t e;
      rsp_ready = 2'b11;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            applyStimulus(0, 32'hFFFF0000, 32'h00FF00FF, 4'b0111, 32'h00FF0000);
         end else begin
            rsp_ready = 2'b01;
            applyStimulus(1, 32'h12345678, 32'h87654321, 4'b1001, 32'h87654321);
            held = 1'b1;
            repeat (4) begin
               @(negedge clk);
               if (rsp_valid !== 2'b10 || rsp_res !== 32'h87654321) held = 1'b0;
            end
            checkCount++;
            if (held) passCount++;
            else $display("[TB] FAIL wrong_port_hold: rsp_valid=%b res=%h required 10 res=87654321",
                          rsp_valid, rsp_res);
            rsp_ready = 2'b10;
         end
         waitResp(p, r, to);
         checkCount++;
         if (!to && sb.size() > 0) begin
            e = sb.pop_front();
            if (p === e.port && r === e.res) passCount++;
            else $display("[TB] FAIL wrong_port_resp%0d: port=%0d res=%h required port%0d res=%h",
                          k, p, r, e.port, e.res);
         end else begin
            $display("[TB] FAIL wrong_port_resp%0d: no response, required one", k);
         end
      end
      checkCount++;
      if (rsp_valid === 2'b00 && busy === 1'b0) passCount++;
      else $display("[TB] FAIL wrong_port_done: rsp_valid=%b busy=%b required 00/0", rsp_valid, busy);
      rsp_ready = 2'b11;
   endtask

   task automatic test_ops();
      int p;
      logic [31:0] r;
      bit to;
      sbEntry_t e;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(i % 2, opA[i], opB[i], opC[i], opR[i]);
         waitResp(p, r, to);
         checkCount++;
         if (!to && sb.size() > 0) begin
            e = sb.pop_front();
            if (p === e.port && r === e.res) passCount++;
            else $display("[TB] FAIL op%0d_%b: port=%0d res=%h required port%0d res=%h",
                          i, opC[i], p, r, e.port, e.res);
         end else begin
            $display("[TB] FAIL op%0d_%b: no response, required one", i, opC[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_round_robin();
      test_fixed_priority();
      test_backpressure();
      test_reset_mid_exec();
      test_wrong_port();
      test_ops();
      checkCount++;
      if (sb.size() == 0) passCount++;
      else $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
